// File: rtl/dmem_pkg.sv
// Shared types and constants for the DMEM responder: funct3 encodings, FSM states,
// and the captured-request record.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_W = 2;   // byte lane select within a 32-bit word
  localparam int ADDR_W = 10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [2:0]        f3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// RV32I lane steering for one access: store byte enables / replicated data,
// load lane extraction with sign or zero extension, and access-legality checks.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_store,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rword,
  output logic [3:0]        byte_en,
  output logic [31:0]       wword,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic              bad_f3
);

  logic [31:0] bshift;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  assign bshift = rword >> {lane, 3'b000};
  assign bsel   = bshift[7:0];
  assign hsel   = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en  = 4'b0000;
    wword    = wdata;
    rdata    = '0;
    misalign = 1'b0;

    // funct3[1:0] encodes the access size for every legal encoding
    case (funct3[1:0])
      2'b01:   misalign = lane[0];
      2'b10:   misalign = |lane;
      default: misalign = 1'b0;
    endcase

    if (is_store)
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      bad_f3 = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wword   = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wword   = {2{wdata[15:0]}};
      end
      default: byte_en = 4'b1111;
    endcase

    case (funct3)
      F3_B:    rdata = {{24{bsel[7]}}, bsel};
      F3_BU:   rdata = {24'd0, bsel};
      F3_H:    rdata = {{16{hsel[15]}}, hsel};
      F3_HU:   rdata = {16'd0, hsel};
      F3_W:    rdata = rword;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// DMEM target: one load/store in flight, WAIT_CYCLES busy cycles, then a single
// registered mem_ready pulse carrying the aligned load data or a fault flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [31:0]       write_data_DMEM,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  output logic [31:0]       data_DMEM,
  output logic              mem_ready,
  output logic              mem_fault
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  dmem_state_t state;
  logic [3:0]  cnt;
  dmem_req_t   req_q, live, cur;

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0]  widx;
  logic        in_range, req_live, enter_done, fault, commit;
  logic [31:0] rword, wword, rdata;
  logic [3:0]  byte_en;
  logic        misalign, bad_f3;

  assign req_live = MemRead | MemWrite;

  // With zero wait states the access resolves on the accepting edge itself,
  // so the live request feeds the datapath while idle.
  always_comb begin
    live = '{rd: MemRead, wr: MemWrite, f3: funct3, addr: address_DMEM,
             wdata: write_data_DMEM};
    cur  = (state == IDLE) ? live : req_q;
  end

  assign widx     = cur.addr[ADDR_W-1:2];
  assign in_range = int'(widx) < DEPTH_WORDS;
  assign rword    = in_range ? mem[widx[IDX_W-1:0]] : '0;

  dmem_lane_align u_align (
    .funct3   (cur.f3),
    .lane     (cur.addr[LANE_W-1:0]),
    .is_store (cur.wr),
    .wdata    (cur.wdata),
    .rword    (rword),
    .byte_en  (byte_en),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (misalign),
    .bad_f3   (bad_f3)
  );

  assign enter_done = ((state == IDLE) && req_live && (WAIT_CYCLES == 0)) ||
                      ((state == BUSY) && (cnt == 4'd1));
  assign fault      = (cur.rd & cur.wr) | misalign | bad_f3 | !in_range;
  assign commit     = enter_done & !RST & cur.wr & !fault;

  // Array is deliberately not reset; only the addressed lanes are touched.
  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[widx[IDX_W-1:0]][8*b +: 8] <= wword[8*b +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      data_DMEM <= '0;
      mem_ready <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_ready <= enter_done;
      mem_fault <= enter_done & fault;
      data_DMEM <= (enter_done && cur.rd && !fault) ? rdata : '0;
      case (state)
        IDLE: begin
          if (req_live) begin
            req_q <= live;
            cnt   <= WAIT_LD;
            state <= (WAIT_CYCLES == 0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 2 wait states) checked every cycle
// against a byte-array transaction model, plus hand-computed directed expectations.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2
  logic [1:0]       rst, rd, wr;
  logic [1:0][2:0]  f3;
  logic [1:0][9:0]  addr;
  logic [1:0][31:0] wd;
  logic [1:0][31:0] dout;
  logic [1:0]       rdy, flt;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
    .CLK(CLK), .RST(rst[0]), .address_DMEM(addr[0]), .write_data_DMEM(wd[0]),
    .MemRead(rd[0]), .MemWrite(wr[0]), .funct3(f3[0]),
    .data_DMEM(dout[0]), .mem_ready(rdy[0]), .mem_fault(flt[0]));

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u2 (
    .CLK(CLK), .RST(rst[1]), .address_DMEM(addr[1]), .write_data_DMEM(wd[1]),
    .MemRead(rd[1]), .MemWrite(wr[1]), .funct3(f3[1]),
    .data_DMEM(dout[1]), .mem_ready(rdy[1]), .mem_fault(flt[1]));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [7:0]  mb [2][1024];
  int          n = 0;
  int          free_at [2] = '{0, 0};
  int          done_e  [2] = '{0, 0};
  bit          pend    [2] = '{0, 0};
  logic        prd [2], pwr [2];
  logic [2:0]  pf3 [2];
  logic [9:0]  pa  [2];
  logic [31:0] pwd [2];
  logic        er [2] = '{0, 0};
  logic        ef [2] = '{0, 0};
  logic [31:0] ed [2] = '{0, 0};

  function automatic int wt(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic resolve(input int i);
    int sz;
    logic bad;
    logic [31:0] v;
    sz  = 1 << pf3[i][1:0];
    bad = prd[i] && pwr[i];
    if (pwr[i] && !prd[i]) bad = bad || (pf3[i] > 3'd2);
    if (prd[i] && !pwr[i]) bad = bad || (pf3[i] == 3'd3) || (pf3[i] >= 3'd6);
    bad = bad || ((int'(pa[i]) % sz) != 0);
    v = '0;
    if (!bad && pwr[i])
      for (int b = 0; b < sz; b++) mb[i][int'(pa[i]) + b] = pwd[i][8*b +: 8];
    if (!bad && prd[i]) begin
      for (int b = 0; b < sz; b++) v = v | (32'(mb[i][int'(pa[i]) + b]) << (8*b));
      if (!pf3[i][2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
    end
    er[i] = 1'b1;
    ef[i] = bad;
    ed[i] = v;
  endtask

  always @(posedge CLK) begin
    n++;
    for (int i = 0; i < 2; i++) begin
      er[i] = 1'b0; ef[i] = 1'b0; ed[i] = '0;
      if (rst[i]) begin
        pend[i]    = 1'b0;
        free_at[i] = n + 1;
      end else begin
        if (!pend[i] && n >= free_at[i] && (rd[i] || wr[i])) begin
          pend[i] = 1'b1; done_e[i] = n + wt(i);
          prd[i] = rd[i]; pwr[i] = wr[i]; pf3[i] = f3[i]; pa[i] = addr[i]; pwd[i] = wd[i];
        end
        if (pend[i] && n == done_e[i]) begin
          resolve(i);
          pend[i]    = 1'b0;
          free_at[i] = n + 2;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (n >= 1) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc_ready u%0d", i), 32'(rdy[i]), 32'(er[i]));
        chk($sformatf("cyc_fault u%0d", i), 32'(flt[i]), 32'(ef[i]));
        chk($sformatf("cyc_data u%0d", i), dout[i], ed[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input int i, input logic r, input logic w, input logic [2:0] f,
                     input logic [9:0] a, input logic [31:0] data,
                     output logic [31:0] d, output logic fl, output int lat);
    rd[i] = r; wr[i] = w; f3[i] = f; addr[i] = a; wd[i] = data;
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!rdy[i] && lat < 40);
    d  = dout[i];
    fl = flt[i];
    if (!rdy[i]) begin
      tests++; fails++;
      $display("FAIL acc_timeout u%0d: no mem_ready after %0d cycles", i, lat);
    end
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(negedge CLK);
  endtask

  logic [31:0] d;
  logic        fl;
  int          lat, rc;
  logic [2:0]  lt [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    rst = '1; rd = '0; wr = '0; f3 = '0; addr = '0; wd = '0;
    repeat (2) @(negedge CLK);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_fault", 32'(flt), 32'd0);
    chk("reset_data", dout[1], 32'd0);
    rst = '0;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 64; w++)
        acc(i, 1'b0, 1'b1, F3_W, 10'(w*4), $urandom, d, fl, lat);

    // directed, 2 wait states
    acc(1, 0, 1, F3_W, 10'h010, 32'hDEADBEEF, d, fl, lat);
    chk("sw_latency", 32'(lat), 32'd3);
    chk("sw_fault", 32'(fl), 32'd0);
    acc(1, 1, 0, F3_W,  10'h010, 0, d, fl, lat); chk("lw", d, 32'hDEADBEEF);
    acc(1, 1, 0, F3_B,  10'h013, 0, d, fl, lat); chk("lb", d, 32'hFFFFFFDE);
    acc(1, 1, 0, F3_BU, 10'h013, 0, d, fl, lat); chk("lbu", d, 32'h000000DE);
    acc(1, 1, 0, F3_H,  10'h012, 0, d, fl, lat); chk("lh", d, 32'hFFFFDEAD);
    acc(1, 1, 0, F3_HU, 10'h010, 0, d, fl, lat); chk("lhu", d, 32'h0000BEEF);
    acc(1, 0, 1, F3_B,  10'h011, 32'h55, d, fl, lat);
    acc(1, 1, 0, F3_W,  10'h010, 0, d, fl, lat); chk("sb_merge", d, 32'hDEAD55EF);
    acc(1, 0, 1, F3_H,  10'h012, 32'h1234, d, fl, lat);
    acc(1, 1, 0, F3_W,  10'h010, 0, d, fl, lat); chk("sh_merge", d, 32'h123455EF);
    acc(1, 1, 0, F3_W,  10'h012, 0, d, fl, lat);
    chk("lw_misal_fault", 32'(fl), 32'd1); chk("lw_misal_data", d, 32'd0);
    acc(1, 0, 1, F3_H,  10'h011, 32'hFFFF, d, fl, lat); chk("sh_misal_fault", 32'(fl), 32'd1);
    acc(1, 1, 0, F3_W,  10'h010, 0, d, fl, lat); chk("sh_misal_nowrite", d, 32'h123455EF);
    acc(1, 1, 1, F3_W,  10'h010, 0, d, fl, lat); chk("rdwr_fault", 32'(fl), 32'd1);

    // reset while busy aborts the store
    acc(1, 0, 1, F3_W, 10'h020, 32'h0, d, fl, lat);
    wr[1] = 1'b1; f3[1] = F3_W; addr[1] = 10'h020; wd[1] = 32'hCAFEF00D;
    @(negedge CLK);
    wr[1] = 1'b0; rst[1] = 1'b1;
    @(negedge CLK);
    rst[1] = 1'b0; rc = 0;
    repeat (6) begin @(negedge CLK); rc += int'(rdy[1]); end
    chk("rst_no_ready", 32'(rc), 32'd0);
    acc(1, 1, 0, F3_W, 10'h020, 0, d, fl, lat); chk("rst_no_commit", d, 32'h0);

    // zero wait states, request held continuously
    wr[0] = 1'b1; f3[0] = F3_W; rc = 0;
    for (int k = 1; k <= 20; k++) begin
      addr[0] = 10'($urandom_range(0, 15) * 4); wd[0] = $urandom;
      @(negedge CLK);
      chk("b2b_st_pattern", 32'(rdy[0]), 32'(k % 2));
      rc += int'(rdy[0]);
    end
    wr[0] = 1'b0;
    chk("b2b_st_count", 32'(rc), 32'd10);
    @(negedge CLK);
    rd[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      addr[0] = 10'($urandom_range(0, 63)); f3[0] = lt[$urandom_range(0, 4)];
      @(negedge CLK);
      chk("b2b_ld_pattern", 32'(rdy[0]), 32'(k % 2));
    end
    rd[0] = 1'b0;
    @(negedge CLK);

    // randomized traffic on the 2-wait instance, inputs wander while busy
    for (int it = 0; it < 150; it++) begin
      int kind, cyc;
      bit done;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      kind = $urandom_range(0, 8);
      rd[1] = (kind < 4) || (kind == 8);
      wr[1] = (kind >= 4);
      f3[1] = 3'($urandom_range(0, 7)); addr[1] = 10'($urandom_range(0, 255)); wd[1] = $urandom;
      cyc = 0; done = 0;
      while (!done) begin
        @(negedge CLK); cyc++;
        if (rdy[1]) done = 1;
        else if ($urandom_range(0, 29) == 0) begin
          rd[1] = 1'b0; wr[1] = 1'b0; rst[1] = 1'b1;
          @(negedge CLK);
          rst[1] = 1'b0; done = 1;
        end else if (cyc >= 40) begin
          tests++; fails++;
          $display("FAIL rand_timeout: no mem_ready after %0d cycles", cyc);
          done = 1;
        end else if ($urandom_range(0, 3) == 0) begin
          f3[1] = 3'($urandom_range(0, 7)); addr[1] = 10'($urandom_range(0, 255)); wd[1] = $urandom;
        end
      end
      rd[1] = 1'b0; wr[1] = 1'b0;
      @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
